// File: rtl/seq_control_pkg.sv
`default_nettype none
// ============================================================================
// seq_control_pkg : opcode / ALU-select encodings and decode helpers
// Rev 1.0 - initial release
// ============================================================================
package seq_control_pkg;

    typedef logic [6:0] opcode_t;

    localparam opcode_t OPC_LOAD   = 7'b0000011;
    localparam opcode_t OPC_FENCE  = 7'b0001111;
    localparam opcode_t OPC_IMM    = 7'b0010011;
    localparam opcode_t OPC_AUIPC  = 7'b0010111;
    localparam opcode_t OPC_STORE  = 7'b0100011;
    localparam opcode_t OPC_OP     = 7'b0110011;
    localparam opcode_t OPC_LUI    = 7'b0110111;
    localparam opcode_t OPC_BRANCH = 7'b1100011;
    localparam opcode_t OPC_JALR   = 7'b1100111;
    localparam opcode_t OPC_JAL    = 7'b1101111;
    localparam opcode_t OPC_SYS    = 7'b1110011;

    typedef enum logic [2:0] {
        ALU_NONE      = 3'd0,
        ALU_PC_4      = 3'd1,
        ALU_PC_IMM    = 3'd2,
        ALU_RS1_4     = 3'd3,
        ALU_RS1_IMM   = 3'd4,
        ALU_OPEXE     = 3'd5,
        ALU_BRANCH_OP = 3'd6
    } alu_ctrl_t;

    // Default step loaded on reset; the sequencer's RESET_STEP defaults to this.
    localparam logic [1:0] CYCLE_INIT = 2'd0;

    function automatic logic is_legal_opcode(input opcode_t opc);
        case (opc)
            OPC_LOAD, OPC_FENCE, OPC_IMM, OPC_AUIPC, OPC_STORE, OPC_OP,
            OPC_LUI, OPC_BRANCH, OPC_JALR, OPC_JAL, OPC_SYS: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] max_step(input opcode_t opc);
        case (opc)
            OPC_OP, OPC_LOAD, OPC_STORE, OPC_JALR:                  return 2'd2;
            OPC_BRANCH:                                             return 2'd3;
            OPC_IMM, OPC_JAL, OPC_AUIPC, OPC_LUI, OPC_FENCE, OPC_SYS: return 2'd1;
            default:                                                return 2'd0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_control_if.sv
`default_nettype none
// ============================================================================
// seq_control_if : instruction-side inputs and datapath controls of seq_control
// Rev 1.0 - initial release
// ============================================================================
interface seq_control_if #(
    parameter int SLW = 1
);
    logic [6:0]                 opcode;
    logic                       mem_ready;
    logic [6:0]                 op;
    logic [1:0]                 step;
    logic [1:0]                 max_step;
    logic [SLW-1:0]             slice;
    logic                       first;
    logic                       step_adv;
    seq_control_pkg::alu_ctrl_t alu_ctrl;
    logic                       update_pc;
    logic                       update_instr;
    logic                       rf_rs1;
    logic                       rf_rs2;
    logic                       save_rd;
    logic                       save_pc;
    logic                       rf_wren;
    logic                       mem_rden;
    logic                       mem_wren;
    logic                       trap;
    logic                       illegal;

    modport master (
        output opcode, mem_ready,
        input  op, step, max_step, slice, first, step_adv, alu_ctrl,
               update_pc, update_instr, rf_rs1, rf_rs2, save_rd, save_pc,
               rf_wren, mem_rden, mem_wren, trap, illegal
    );

    modport slave (
        input  opcode, mem_ready,
        output op, step, max_step, slice, first, step_adv, alu_ctrl,
               update_pc, update_instr, rf_rs1, rf_rs2, save_rd, save_pc,
               rf_wren, mem_rden, mem_wren, trap, illegal
    );
endinterface
`default_nettype wire

// File: rtl/seq_control_slice_counter.sv
`default_nettype none
// ============================================================================
// seq_control_slice_counter : slice position within a step, memory stall hold
// Rev 1.0 - initial release
// ============================================================================
module seq_control_slice_counter #(
    parameter int NSLICE   = 1,
    parameter int SLW      = 1,
    parameter int MEM_WAIT = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_mem_step,
    input  logic           i_mem_ready,
    output logic [SLW-1:0] o_slice,
    output logic           o_slice_last,
    output logic           o_first,
    output logic           o_stall_rep,
    output logic           o_step_adv
);

    logic w_slice_last;
    logic w_step_adv;
    logic r_first;
    logic r_held;

    assign w_step_adv = w_slice_last && (!i_mem_step || (MEM_WAIT == 0) || i_mem_ready);

    generate
        if (NSLICE == 1) begin : g_single
            assign w_slice_last = 1'b1;
            assign o_slice      = '0;
        end else begin : g_multi
            logic [SLW-1:0] r_slice;

            // Parks on the final slice while memory has not answered.
            always_ff @(posedge clk) begin
                if (rst)
                    r_slice <= '0;
                else if (w_step_adv)
                    r_slice <= '0;
                else if (!w_slice_last)
                    r_slice <= r_slice + SLW'(1);
            end

            assign w_slice_last = (r_slice == SLW'(NSLICE - 1));
            assign o_slice      = r_slice;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_first <= 1'b1;
            r_held  <= 1'b0;
        end else begin
            r_first <= w_step_adv;
            r_held  <= w_slice_last && !w_step_adv;
        end
    end

    assign o_slice_last = w_slice_last;
    assign o_first      = r_first;
    assign o_stall_rep  = r_held;
    assign o_step_adv   = w_step_adv;

endmodule
`default_nettype wire

// File: rtl/seq_control.sv
`default_nettype none
// ============================================================================
// seq_control : multi-cycle, slice-serial RV32I instruction sequencer
// Rev 1.0 - initial release
// ============================================================================
module seq_control
    import seq_control_pkg::*;
#(
    parameter int         XLEN       = 32,
    parameter int         SLICE_W    = 32,
    parameter int         MEM_WAIT   = 1,
    parameter logic [1:0] RESET_STEP = CYCLE_INIT
) (
    input  logic          clk,
    input  logic          rst,
    seq_control_if.slave  bus
);

    localparam int NSLICE = XLEN / SLICE_W;
    localparam int SLW    = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    logic [4:0]     r_op5;
    logic           r_lowok;
    logic [1:0]     r_step;

    opcode_t        w_opc;
    logic [1:0]     w_max;
    logic           w_illegal;
    logic           w_is_op, w_is_imm, w_is_load, w_is_store, w_is_branch;
    logic           w_is_jal, w_is_jalr, w_is_auipc, w_is_lui, w_is_fence, w_is_sys;
    logic           w_update_pc, w_mem_rd_step, w_mem_wr_step, w_mem_step;
    logic [SLW-1:0] w_slice;
    logic           w_slice_last, w_first, w_stall_rep, w_step_adv;
    logic [1:0]     w_step_nxt;
    logic           w_op_load;
    alu_ctrl_t      w_alu;
    logic           w_update_instr, w_rf_rs1, w_rf_rs2, w_save_rd, w_save_pc;
    logic           w_rf_wren, w_mem_rden, w_mem_wren, w_trap;

    // The op output always shows 2'b11; non-11 low bits only feed legality.
    assign w_opc       = {r_op5, (r_lowok ? 2'b11 : 2'b00)};
    assign w_max       = max_step(w_opc);
    assign w_illegal   = !is_legal_opcode(w_opc);
    assign w_is_op     = (w_opc == OPC_OP);
    assign w_is_imm    = (w_opc == OPC_IMM);
    assign w_is_load   = (w_opc == OPC_LOAD);
    assign w_is_store  = (w_opc == OPC_STORE);
    assign w_is_branch = (w_opc == OPC_BRANCH);
    assign w_is_jal    = (w_opc == OPC_JAL);
    assign w_is_jalr   = (w_opc == OPC_JALR);
    assign w_is_auipc  = (w_opc == OPC_AUIPC);
    assign w_is_lui    = (w_opc == OPC_LUI);
    assign w_is_fence  = (w_opc == OPC_FENCE);
    assign w_is_sys    = (w_opc == OPC_SYS);

    assign w_update_pc   = (w_is_op || w_is_jalr) ? (r_step == 2'd1) :
                           w_is_branch            ? (r_step == 2'd0 || r_step == 2'd2) :
                                                    (r_step == 2'd0);
    assign w_mem_rd_step = w_update_pc || (w_is_load && r_step == 2'd1);
    assign w_mem_wr_step = w_is_store && (r_step == 2'd2);
    assign w_mem_step    = w_mem_rd_step || w_mem_wr_step;

    seq_control_slice_counter #(
        .NSLICE   (NSLICE),
        .SLW      (SLW),
        .MEM_WAIT (MEM_WAIT)
    ) u_slice (
        .clk          (clk),
        .rst          (rst),
        .i_mem_step   (w_mem_step),
        .i_mem_ready  (bus.mem_ready),
        .o_slice      (w_slice),
        .o_slice_last (w_slice_last),
        .o_first      (w_first),
        .o_stall_rep  (w_stall_rep),
        .o_step_adv   (w_step_adv)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_step  <= RESET_STEP;
            r_op5   <= bus.opcode[6:2];
            r_lowok <= (bus.opcode[1:0] == 2'b11);
        end else begin
            r_step <= w_step_nxt;
            if (w_op_load) begin
                r_op5   <= bus.opcode[6:2];
                r_lowok <= (bus.opcode[1:0] == 2'b11);
            end
        end
    end

    always_comb begin
        w_step_nxt = r_step;
        w_op_load  = 1'b0;
        if (w_step_adv) begin
            if (r_step == w_max) begin
                w_step_nxt = 2'd0;
                w_op_load  = 1'b1;
            end else begin
                w_step_nxt = r_step + 2'd1;
            end
        end
    end

    always_comb begin
        w_rf_rs1 = 1'b0;
        w_rf_wren = 1'b0;
        w_alu = ALU_NONE;

        if (w_is_branch)
            w_rf_rs1 = (r_step == 2'd1);
        else if (!(w_is_jal || w_is_lui || w_is_auipc || w_is_sys || w_is_fence || w_illegal))
            w_rf_rs1 = (r_step == 2'd0);

        w_rf_rs2  = ((w_is_op || w_is_store) && r_step == 2'd1) || (w_is_branch && r_step == 2'd0);
        w_save_rd = (r_step == 2'd0) && w_first;
        w_save_pc = (w_is_branch || w_is_jal || w_is_auipc) && (r_step == 2'd0) && w_first;

        // Writeback is single-shot: stall repeats of the final slice stay quiet.
        if (w_is_lui)
            w_rf_wren = (r_step == 2'd0);
        else if (!(w_is_store || w_is_branch || w_is_fence || w_illegal))
            w_rf_wren = (r_step == w_max);
        w_rf_wren = w_rf_wren && !w_stall_rep;

        w_mem_rden     = w_mem_rd_step && w_slice_last;
        w_mem_wren     = w_mem_wr_step && w_slice_last;
        w_update_instr = w_step_adv && ((w_is_load || w_is_store) ? (r_step == 2'd1)
                                                                  : (r_step == w_max));

        case (r_step)
            2'd0: w_alu = w_is_op ? ALU_NONE : (w_is_jal ? ALU_PC_IMM : ALU_PC_4);
            2'd1: begin
                if (w_is_op)                                              w_alu = ALU_PC_4;
                else if (w_is_imm)                                        w_alu = ALU_OPEXE;
                else if (w_is_jal)                                        w_alu = ALU_RS1_4;
                else if (w_is_lui || w_is_fence || w_is_sys || w_illegal) w_alu = ALU_NONE;
                else                                                      w_alu = ALU_RS1_IMM;
            end
            2'd2: w_alu = w_is_op ? ALU_OPEXE : (w_is_branch ? ALU_BRANCH_OP : ALU_NONE);
            default: w_alu = ALU_NONE;
        endcase

        w_trap = (r_step == 2'd0) && w_first && (w_is_sys || w_illegal);
    end

    assign bus.op           = {r_op5, 2'b11};
    assign bus.step         = r_step;
    assign bus.max_step     = w_max;
    assign bus.slice        = w_slice;
    assign bus.first        = w_first;
    assign bus.step_adv     = w_step_adv;
    assign bus.alu_ctrl     = w_alu;
    assign bus.update_pc    = w_update_pc;
    assign bus.update_instr = w_update_instr;
    assign bus.rf_rs1       = w_rf_rs1;
    assign bus.rf_rs2       = w_rf_rs2;
    assign bus.save_rd      = w_save_rd;
    assign bus.save_pc      = w_save_pc;
    assign bus.rf_wren      = w_rf_wren;
    assign bus.mem_rden     = w_mem_rden;
    assign bus.mem_wren     = w_mem_wren;
    assign bus.trap         = w_trap;
    assign bus.illegal      = w_illegal;

endmodule
`default_nettype wire

// File: tb/tb_seq_control.sv
`default_nettype none
// ============================================================================
// tb_seq_control : random-stimulus bench for two seq_control configurations
// Rev 1.0 - initial release
// ============================================================================
module tb_seq_control;
    import seq_control_pkg::*;

    localparam logic [6:0] T_LOAD   = 7'h03, T_FENCE = 7'h0F, T_IMM  = 7'h13;
    localparam logic [6:0] T_AUIPC  = 7'h17, T_STORE = 7'h23, T_OP   = 7'h33;
    localparam logic [6:0] T_LUI    = 7'h37, T_BRANCH = 7'h63, T_JALR = 7'h67;
    localparam logic [6:0] T_JAL    = 7'h6F, T_SYS   = 7'h73;
    localparam int NCYC = 3000;

    typedef struct packed {
        logic [6:0] op;
        logic [1:0] step;
        logic [1:0] max_step;
        logic [1:0] slice;
        logic       first;
        logic       step_adv;
        logic [2:0] alu;
        logic       upc, uin, rs1, rs2, srd, spc, wren, rden, mwren, trap, ill;
    } obs_t;

    logic clk = 1'b0;
    logic rst;
    logic [6:0] cur_opc;
    logic       cur_rdy;

    seq_control_if #(.SLW(1)) bus0 ();
    seq_control_if #(.SLW(2)) bus1 ();

    // u0: full width, waits on memory; u1: byte-serial, single-cycle memory, reset mid-sequence
    seq_control #(.XLEN(32), .SLICE_W(32), .MEM_WAIT(1), .RESET_STEP(2'd0))
        u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
    seq_control #(.XLEN(32), .SLICE_W(8), .MEM_WAIT(0), .RESET_STEP(2'd1))
        u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

    always #5 clk = ~clk;

    assign bus0.opcode = cur_opc;
    assign bus1.opcode = cur_opc;
    assign bus0.mem_ready = cur_rdy;
    assign bus1.mem_ready = cur_rdy;

    obs_t obs0, obs1;
    always_comb begin
        obs0 = '{bus0.op, bus0.step, bus0.max_step, {1'b0, bus0.slice}, bus0.first,
                 bus0.step_adv, bus0.alu_ctrl, bus0.update_pc, bus0.update_instr,
                 bus0.rf_rs1, bus0.rf_rs2, bus0.save_rd, bus0.save_pc, bus0.rf_wren,
                 bus0.mem_rden, bus0.mem_wren, bus0.trap, bus0.illegal};
        obs1 = '{bus1.op, bus1.step, bus1.max_step, bus1.slice, bus1.first,
                 bus1.step_adv, bus1.alu_ctrl, bus1.update_pc, bus1.update_instr,
                 bus1.rf_rs1, bus1.rf_rs2, bus1.save_rd, bus1.save_pc, bus1.rf_wren,
                 bus1.mem_rden, bus1.mem_wren, bus1.trap, bus1.illegal};
    end

    int n_chk = 0;
    int n_pass = 0;
    int cyc_i = 0;

    task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s cycle %0d: got %0d expected %0d", tag, cyc_i, got, exp);
    endtask

    function automatic int ns_of(input int k);  return (k == 0) ? 1 : 4; endfunction
    function automatic int mw_of(input int k);  return (k == 0) ? 1 : 0; endfunction
    function automatic int rs_of(input int k);  return (k == 0) ? 0 : 1; endfunction

    // Number of steps each instruction class takes; undefined encodings take one.
    function automatic int nsteps(input logic [6:0] c);
        case (c)
            T_OP, T_LOAD, T_STORE, T_JALR:                   return 3;
            T_BRANCH:                                        return 4;
            T_IMM, T_JAL, T_AUIPC, T_LUI, T_FENCE, T_SYS:    return 2;
            default:                                         return 1;
        endcase
    endfunction

    // Reference state: opcode in flight, current step, cycles spent in that step.
    logic [6:0] m_opc [2];
    int         m_step [2];
    int         m_cyc [2];
    bit         m_valid [2];

    function automatic obs_t expect_of(input int k, input logic rdy);
        obs_t e;
        logic [6:0] c;
        int s, ns, last;
        bit leg, fetch, memrd, memwr, slast, first, rep;
        c = m_opc[k]; s = m_step[k]; ns = ns_of(k);
        leg = c inside {T_LOAD, T_FENCE, T_IMM, T_AUIPC, T_STORE, T_OP,
                        T_LUI, T_BRANCH, T_JALR, T_JAL, T_SYS};
        last  = nsteps(c) - 1;
        first = (m_cyc[k] == 0);
        slast = (m_cyc[k] >= ns - 1);
        rep   = (m_cyc[k] >= ns);
        if (c == T_OP || c == T_JALR) fetch = (s == 1);
        else if (c == T_BRANCH)       fetch = (s == 0 || s == 2);
        else                          fetch = (s == 0);
        memrd = fetch || (c == T_LOAD && s == 1);
        memwr = (c == T_STORE && s == 2);

        e = '0;
        e.op       = {c[6:2], 2'b11};
        e.step     = 2'(s);
        e.max_step = 2'(last);
        e.slice    = 2'((m_cyc[k] < ns) ? m_cyc[k] : ns - 1);
        e.first    = first;
        e.step_adv = slast && (!(memrd || memwr) || mw_of(k) == 0 || rdy);
        e.upc      = fetch;
        e.rs1      = (c == T_BRANCH) ? (s == 1) :
                     (!leg || c inside {T_JAL, T_LUI, T_AUIPC, T_SYS, T_FENCE}) ? 1'b0 : (s == 0);
        e.rs2      = ((c == T_OP || c == T_STORE) && s == 1) || (c == T_BRANCH && s == 0);
        e.srd      = (s == 0) && first;
        e.spc      = (c inside {T_BRANCH, T_JAL, T_AUIPC}) && s == 0 && first;
        if (!leg || c inside {T_STORE, T_BRANCH, T_FENCE}) e.wren = 1'b0;
        else if (c == T_LUI)                               e.wren = (s == 0) && !rep;
        else                                               e.wren = (s == last) && !rep;
        e.rden     = memrd && slast;
        e.mwren    = memwr && slast;
        e.uin      = e.step_adv && ((c == T_LOAD || c == T_STORE) ? (s == 1) : (s == last));
        case (s)
            0: e.alu = (c == T_OP) ? ALU_NONE : (c == T_JAL) ? ALU_PC_IMM : ALU_PC_4;
            1: begin
                if (c == T_OP)                                e.alu = ALU_PC_4;
                else if (c == T_IMM)                          e.alu = ALU_OPEXE;
                else if (c == T_JAL)                          e.alu = ALU_RS1_4;
                else if (!leg || c inside {T_LUI, T_FENCE, T_SYS}) e.alu = ALU_NONE;
                else                                          e.alu = ALU_RS1_IMM;
            end
            2: e.alu = (c == T_OP) ? ALU_OPEXE : (c == T_BRANCH) ? ALU_BRANCH_OP : ALU_NONE;
            default: e.alu = ALU_NONE;
        endcase
        e.trap = (s == 0) && first && (c == T_SYS || !leg);
        e.ill  = !leg;
        return e;
    endfunction

    task automatic compare(input int k, input obs_t o, input obs_t e);
        string p;
        p = $sformatf("u%0d.", k);
        chk({p, "op"},           o.op,       e.op);
        chk({p, "step"},         o.step,     e.step);
        chk({p, "max_step"},     o.max_step, e.max_step);
        chk({p, "slice"},        o.slice,    e.slice);
        chk({p, "first"},        o.first,    e.first);
        chk({p, "step_adv"},     o.step_adv, e.step_adv);
        chk({p, "alu_ctrl"},     o.alu,      e.alu);
        chk({p, "update_pc"},    o.upc,      e.upc);
        chk({p, "update_instr"}, o.uin,      e.uin);
        chk({p, "rf_rs1"},       o.rs1,      e.rs1);
        chk({p, "rf_rs2"},       o.rs2,      e.rs2);
        chk({p, "save_rd"},      o.srd,      e.srd);
        chk({p, "save_pc"},      o.spc,      e.spc);
        chk({p, "rf_wren"},      o.wren,     e.wren);
        chk({p, "mem_rden"},     o.rden,     e.rden);
        chk({p, "mem_wren"},     o.mwren,    e.mwren);
        chk({p, "trap"},         o.trap,     e.trap);
        chk({p, "illegal"},      o.ill,      e.ill);
    endtask

    task automatic advance(input int k, input logic r, input logic [6:0] opc, input logic adv);
        if (r) begin
            m_valid[k] = 1'b1;
            m_opc[k]   = opc;
            m_step[k]  = rs_of(k);
            m_cyc[k]   = 0;
        end else if (m_valid[k]) begin
            if (adv) begin
                m_cyc[k] = 0;
                if (m_step[k] == nsteps(m_opc[k]) - 1) begin
                    m_step[k] = 0;
                    m_opc[k]  = opc;
                end else begin
                    m_step[k] = (m_step[k] + 1) % 4;
                end
            end else begin
                m_cyc[k]++;
            end
        end
    endtask

    logic [6:0] pool [14];

    initial begin
        obs_t e;
        pool = '{T_LOAD, T_FENCE, T_IMM, T_AUIPC, T_STORE, T_OP, T_LUI,
                 T_BRANCH, T_JALR, T_JAL, T_SYS, 7'h00, 7'h0B, 7'h7F};
        for (int k = 0; k < 2; k++) begin
            m_valid[k] = 1'b0; m_opc[k] = '0; m_step[k] = 0; m_cyc[k] = 0;
        end
        rst = 1'b1; cur_opc = T_OP; cur_rdy = 1'b1;
        for (int i = 0; i < NCYC; i++) begin
            @(negedge clk);
            cyc_i = i;
            for (int k = 0; k < 2; k++) begin
                e = expect_of(k, cur_rdy);
                if (m_valid[k]) compare(k, (k == 0) ? obs0 : obs1, e);
                advance(k, rst, cur_opc, e.step_adv);
            end
            @(posedge clk);
            #1;
            // Cycles 280-299 starve memory so the reset at 300 lands inside a stall.
            rst     = (i == 300) || ($urandom_range(0, 199) == 0);
            cur_opc = (i < 20) ? ((i[0]) ? T_IMM : T_OP) : pool[$urandom_range(0, 13)];
            cur_rdy = (i >= 280 && i < 300) ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
